// File: rtl/jtag_bscan_tap_if.sv
// JTAG pins plus boundary-scan pad/core signals of jtag_bscan_tap, grouped for
// the DUT (slave) and the driving side (master).
interface jtag_bscan_tap_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 11
);
    logic             tck;
    logic             tms;
    logic             tdi;
    logic             tdo;
    logic             tdo_en;
    logic [IN_W-1:0]  pin_in;
    logic [IN_W-1:0]  core_in;
    logic [OUT_W-1:0] core_out;
    logic [OUT_W-1:0] pin_out;

    // No valid/ready pair: tms/tdi are qualified by tck rising edges, tdo moves on
    // tck falling edges, and the pad/core buses are level signals with no handshake.
    modport slave (
        input  tck, tms, tdi, pin_in, core_out,
        output tdo, tdo_en, core_in, pin_out
    );

    modport master (
        output tck, tms, tdi, pin_in, core_out,
        input  tdo, tdo_en, core_in, pin_out
    );
endinterface

// File: rtl/jtag_bscan_tap.sv
// IEEE 1149.1 TAP with boundary-scan register, oversampled on clk.
// Optional IDCODE register enabled by defining JTAG_IDCODE_EN.
module jtag_bscan_tap #(
    parameter int          IN_W       = 11,
    parameter int          OUT_W      = 11,
    parameter int          IR_W       = 3,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            clk,
    input  logic            reset,
    jtag_bscan_tap_if.slave bus,
    output logic [3:0]      tap_state
);
    localparam int BSR_W = IN_W + OUT_W;

    localparam logic [IR_W-1:0] OP_EXTEST  = '0;
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] OP_BYPASS  = '1;
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(2);
    localparam logic [IR_W-1:0] DEFAULT_IR = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] DEFAULT_IR = OP_BYPASS;
`endif

    if (IR_W < 2) begin : g_bad_ir_w
        $error("IR_W must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("IDCODE_VAL bit 0 must be 1");
    end

    // Common 1149.1 state encoding, visible on tap_state for debug.
    typedef enum logic [3:0] {
        EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
        RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
    } tap_t;

    typedef enum logic [1:0] {I_EXTEST, I_SAMPLE, I_IDCODE, I_BYPASS} instr_t;

    tap_t             state;
    tap_t             state_next;
    instr_t           instr;
    logic [1:0]       tck_sync;
    logic [1:0]       tms_sync;
    logic [1:0]       tdi_sync;
    logic             tck_prev;
    logic             tck_rise;
    logic             tck_fall;
    logic             tms_s;
    logic             tdi_s;
    logic [IR_W-1:0]  ir_shift;
    logic [IR_W-1:0]  ir_active;
    logic [BSR_W-1:0] bsr;
    logic [BSR_W-1:0] bsr_upd;
    logic             bypass_reg;
    logic             dr_lsb;
    logic             tdo_q;
    logic             tdo_en_i;
    logic             bsr_sel;
    logic             extest;
`ifdef JTAG_IDCODE_EN
    logic [31:0]      idcode_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[0], bus.tck};
            tms_sync <= {tms_sync[0], bus.tms};
            tdi_sync <= {tdi_sync[0], bus.tdi};
            tck_prev <= tck_sync[1];
        end
    end

    assign tck_rise = tck_sync[1] & ~tck_prev;
    assign tck_fall = ~tck_sync[1] & tck_prev;
    assign tms_s    = tms_sync[1];
    assign tdi_s    = tdi_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= TLR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tck_rise) begin
            case (state)
                TLR:      state_next = tms_s ? TLR      : RTI;
                RTI:      state_next = tms_s ? SEL_DR   : RTI;
                SEL_DR:   state_next = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   state_next = tms_s ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: state_next = tms_s ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: state_next = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_next = tms_s ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: state_next = tms_s ? UPD_DR   : SHIFT_DR;
                UPD_DR:   state_next = tms_s ? SEL_DR   : RTI;
                SEL_IR:   state_next = tms_s ? TLR      : CAP_IR;
                CAP_IR:   state_next = tms_s ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: state_next = tms_s ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: state_next = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_next = tms_s ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: state_next = tms_s ? UPD_IR   : SHIFT_IR;
                UPD_IR:   state_next = tms_s ? SEL_DR   : RTI;
                default:  state_next = TLR;
            endcase
        end
    end

    // Unlisted opcodes fall through to BYPASS.
    always_comb begin
        instr = I_BYPASS;
        if (ir_active == OP_EXTEST)      instr = I_EXTEST;
        else if (ir_active == OP_SAMPLE) instr = I_SAMPLE;
`ifdef JTAG_IDCODE_EN
        else if (ir_active == OP_IDCODE) instr = I_IDCODE;
`endif
    end

    assign bsr_sel = (instr == I_EXTEST) || (instr == I_SAMPLE);
    assign extest  = (instr == I_EXTEST);

    always_comb begin
        dr_lsb = bypass_reg;
        if (bsr_sel) dr_lsb = bsr[0];
`ifdef JTAG_IDCODE_EN
        else if (instr == I_IDCODE) dr_lsb = idcode_reg[0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_shift   <= '0;
            ir_active  <= DEFAULT_IR;
            bsr        <= '0;
            bsr_upd    <= '0;
            bypass_reg <= 1'b0;
            tdo_q      <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idcode_reg <= '0;
`endif
        end else begin
            if (state == TLR) ir_active <= DEFAULT_IR;
            if (tck_rise) begin
                case (state)
                    CAP_IR:   ir_shift <= IR_CAPTURE;
                    SHIFT_IR: ir_shift <= {tdi_s, ir_shift[IR_W-1:1]};
                    UPD_IR:   ir_active <= ir_shift;
                    CAP_DR: begin
                        if (bsr_sel) bsr <= {bus.core_out, bus.pin_in};
                        bypass_reg <= 1'b0;
`ifdef JTAG_IDCODE_EN
                        if (instr == I_IDCODE) idcode_reg <= IDCODE_VAL;
`endif
                    end
                    SHIFT_DR: begin
                        if (bsr_sel) bsr <= {tdi_s, bsr[BSR_W-1:1]};
`ifdef JTAG_IDCODE_EN
                        else if (instr == I_IDCODE) idcode_reg <= {tdi_s, idcode_reg[31:1]};
`endif
                        else bypass_reg <= tdi_s;
                    end
                    UPD_DR:   if (bsr_sel) bsr_upd <= bsr;
                    default:  ;
                endcase
            end
            if (tck_fall) begin
                case (state)
                    SHIFT_IR: tdo_q <= ir_shift[0];
                    SHIFT_DR: tdo_q <= dr_lsb;
                    default:  tdo_q <= 1'b0;
                endcase
            end
        end
    end

    // tdo_q holds across the tck rise that leaves a shift state, so it is masked.
    assign tdo_en_i    = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign bus.tdo_en  = tdo_en_i;
    assign bus.tdo     = tdo_q & tdo_en_i;
    assign bus.pin_out = extest ? bsr_upd[BSR_W-1:IN_W] : bus.core_out;
    assign bus.core_in = extest ? bsr_upd[IN_W-1:0]     : bus.pin_in;
    assign tap_state   = state;
endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Randomized bench for jtag_bscan_tap against a bit-vector model of the scan chains.
module tb_jtag_bscan_tap;
    localparam int          IN_W       = 11;
    localparam int          OUT_W      = 11;
    localparam int          IR_W       = 3;
    localparam int          BSR_W      = IN_W + OUT_W;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
    localparam logic [3:0]  ST_TLR     = 4'hF;
`ifdef JTAG_IDCODE_EN
    localparam int          DEF_OP     = 2;
`else
    localparam int          DEF_OP     = 7;
`endif

    typedef enum {K_EXTEST, K_SAMPLE, K_IDCODE, K_BYPASS} kind_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] tap_state;

    int n_checks = 0;
    int n_pass   = 0;

    int               m_op;
    logic [BSR_W-1:0] m_upd;

    jtag_bscan_tap_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    jtag_bscan_tap #(
        .IN_W(IN_W), .OUT_W(OUT_W), .IR_W(IR_W), .IDCODE_VAL(IDCODE_VAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: run time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic kind_t kind_of(input int op);
        if (op == 0) return K_EXTEST;
        if (op == 1) return K_SAMPLE;
`ifdef JTAG_IDCODE_EN
        if (op == 2) return K_IDCODE;
`endif
        return K_BYPASS;
    endfunction

    // One tck period: low phase (tdo sampled at its end), then high phase.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        @(negedge clk);
        bus.tck = 1'b0;
        bus.tms = tms_v;
        bus.tdi = tdi_v;
        repeat ($urandom_range(5, 8)) @(posedge clk);
        #1;
        tdo_v = bus.tdo;
        bus.tck = 1'b1;
        repeat ($urandom_range(5, 8)) @(posedge clk);
    endtask

    task automatic nav(input logic tms_v);
        logic b;
        tck_cycle(tms_v, 1'b0, b);
    endtask

    // From Run-Test/Idle through Shift-IR and Update-IR back to Run-Test/Idle.
    task automatic scan_ir(input logic [IR_W-1:0] op, output logic [IR_W-1:0] cap);
        logic b;
        nav(1'b1); nav(1'b1); nav(1'b0); nav(1'b0);
        for (int i = 0; i < IR_W; i++) begin
            tck_cycle(i == IR_W - 1, op[i], b);
            cap[i] = b;
        end
        nav(1'b1); nav(1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic b;
        dout = '0;
        nav(1'b1); nav(1'b0); nav(1'b0);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b);
            dout[i] = b;
        end
        nav(1'b1); nav(1'b0);
    endtask

    task automatic load_ir(input string tag, input int op);
        logic [IR_W-1:0] cap;
        scan_ir(IR_W'(op), cap);
        check({tag, "_ir_capture"}, 64'(cap), 64'(1));
        m_op = op;
    endtask

    task automatic check_pins(input string tag);
        logic [OUT_W-1:0] ep;
        logic [IN_W-1:0]  ec;
        #1;
        if (kind_of(m_op) == K_EXTEST) begin
            ep = m_upd[BSR_W-1:IN_W];
            ec = m_upd[IN_W-1:0];
        end else begin
            ep = bus.core_out;
            ec = bus.pin_in;
        end
        check({tag, "_pin_out"}, 64'(bus.pin_out), 64'(ep));
        check({tag, "_core_in"}, 64'(bus.core_in), 64'(ec));
    endtask

    // Data-register scan of the selected register with random tdi.
    task automatic do_dr(input string tag);
        kind_t       k;
        int          n;
        logic [63:0] din, dout, exp, mask;
        k   = kind_of(m_op);
        din = {$urandom, $urandom};
        case (k)
            K_EXTEST, K_SAMPLE: n = BSR_W;
            K_IDCODE:           n = 32;
            default:            n = $urandom_range(2, 20);
        endcase
        mask = (64'd1 << n) - 64'd1;
        din  = din & mask;
        case (k)
            K_EXTEST, K_SAMPLE: exp = 64'({bus.core_out, bus.pin_in});
            K_IDCODE:           exp = 64'(IDCODE_VAL);
            default:            exp = (din << 1) & mask;
        endcase
        scan_dr(n, din, dout);
        check({tag, "_dr_out"}, dout, exp);
        if (k == K_EXTEST || k == K_SAMPLE) m_upd = din[BSR_W-1:0];
        check_pins(tag);
    endtask

    initial begin
        logic [63:0] din, dout;
        logic        b;

        bus.tck = 1'b0; bus.tms = 1'b1; bus.tdi = 1'b0;
        bus.pin_in = IN_W'($urandom); bus.core_out = OUT_W'($urandom);
        reset = 1'b1;
        m_op  = DEF_OP;
        m_upd = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_state", 64'(tap_state), 64'(ST_TLR));
        check("rst_tdo", 64'(bus.tdo), 64'(0));
        check("rst_tdo_en", 64'(bus.tdo_en), 64'(0));
        check_pins("rst");
        @(negedge clk);
        reset = 1'b0;

        // Default instruction read straight out of reset.
        nav(1'b0);
        do_dr("default_ir");

        // BYPASS: 1,0,1,1 in, 0,1,0,1 out.
        load_ir("bypass", 7);
        scan_dr(4, 64'b1101, dout);
        check("bypass_seq", dout, 64'b1010);

        // SAMPLE with fixed pad/core values.
        bus.pin_in = 11'h5A5; bus.core_out = 11'h2C3;
        load_ir("sample", 1);
        din = 64'($urandom) & ((64'd1 << BSR_W) - 64'd1);
        scan_dr(BSR_W, din, dout);
        check("sample_cap", dout, (64'h2C3 << 11) | 64'h5A5);
        m_upd = din[BSR_W-1:0];
        check_pins("sample");

        // PRELOAD all-ones output cells, then EXTEST drives them.
        din = {42'd0, 11'h7FF, 11'($urandom)};
        scan_dr(BSR_W, din, dout);
        check("preload_cap", dout, (64'h2C3 << 11) | 64'h5A5);
        m_upd = din[BSR_W-1:0];
        load_ir("extest", 0);
        for (int i = 0; i < 3; i++) begin
            bus.core_out = OUT_W'($urandom);
            bus.pin_in   = IN_W'($urandom);
            #1;
            check("extest_pin_out", 64'(bus.pin_out), 64'h7FF);
            check_pins("extest");
        end
        load_ir("extest_exit", 7);
        bus.core_out = OUT_W'($urandom);
        check_pins("extest_exit");

        // Five tms=1 from Shift-DR lands in Test-Logic-Reset.
        load_ir("tlr", $urandom_range(3, 7));
        nav(1'b1); nav(1'b0); nav(1'b0);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'($urandom), b);
        for (int i = 0; i < 5; i++) nav(1'b1);
        check("tlr_state", 64'(tap_state), 64'(ST_TLR));
        m_op = DEF_OP;
        nav(1'b0);
        do_dr("tlr_default_ir");

        // Random instructions and pad/core values.
        for (int r = 0; r < 14; r++) begin
            bus.pin_in   = IN_W'($urandom);
            bus.core_out = OUT_W'($urandom);
            load_ir("rand", $urandom_range(0, 7));
            do_dr("rand");
            bus.pin_in   = IN_W'($urandom);
            bus.core_out = OUT_W'($urandom);
            check_pins("rand_after");
        end

        // Reset in the middle of an EXTEST Shift-DR.
        load_ir("rst_mid", 0);
        nav(1'b1); nav(1'b0); nav(1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'($urandom), b);
        check("rst_mid_tdo_en_pre", 64'(bus.tdo_en), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_op  = DEF_OP;
        m_upd = '0;
        check("rst_mid_tdo_en", 64'(bus.tdo_en), 64'(0));
        check("rst_mid_tdo", 64'(bus.tdo), 64'(0));
        check("rst_mid_state", 64'(tap_state), 64'(ST_TLR));
        check_pins("rst_mid");
        bus.tck = 1'b0; bus.tms = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nav(1'b0);
        load_ir("rst_latch", 0);
        check("rst_latch_pin_out", 64'(bus.pin_out), 64'(0));
        check_pins("rst_latch");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/jtag_bscan_tap.md
JTAG_BSCAN_TAP -- requirements
Module: jtag_bscan_tap

Interface
REQ-001 SHALL have parameter IN_W, default 11, the number of input boundary cells (pin to core).
REQ-002 SHALL have parameter OUT_W, default 11, the number of output boundary cells (core to pin).
REQ-003 SHALL have parameter IR_W, default 3 (minimum 2), the instruction register width.
REQ-004 SHALL have parameter IDCODE_VAL, default 32'h1000_0001, the 32-bit device identifier; bit 0 SHALL be 1.
REQ-005 SHALL have ports clk input 1 (system clock) and reset input 1 (asynchronous, active-high); this design has one clock and an asynchronous active-high reset.
REQ-006 SHALL have ports tck, tms and tdi, each input 1: JTAG pins, asynchronous to clk.
REQ-007 SHALL have ports tdo output 1 (serial out) and tdo_en output 1 (high in Shift-IR and Shift-DR only).
REQ-008 SHALL have ports pin_in input IN_W (from pads) and core_in output IN_W (to core).
REQ-009 SHALL have ports core_out input OUT_W (from core) and pin_out output OUT_W (to pads).

Function
REQ-010 SHALL pass tck, tms and tdi each through a 2-flop clk synchronizer; tck_rise and tck_fall SHALL be single-clk pulses on synchronized tck edges.
REQ-011 SHALL function for tck high and low phases of at least 4 clk periods each; behaviour with shorter phases is undefined.
REQ-012 SHALL implement all 16 IEEE 1149.1 TAP states, advancing only on tck_rise using the synchronized tms.
REQ-013 SHALL enter Test-Logic-Reset after 5 consecutive tck_rise with tms=1, from any state.
REQ-014 SHALL use these opcodes: EXTEST=0, SAMPLE/PRELOAD=1, IDCODE=2, BYPASS=all ones; any other opcode SHALL decode as BYPASS.
REQ-015 SHALL load the IR shift stage with binary ...01 (zero-extended to IR_W) in Capture-IR.
REQ-016 SHALL transfer the IR shift stage to the active IR in Update-IR; the active IR SHALL take the default instruction in Test-Logic-Reset.
REQ-017 SHALL shift all shift stages right by one bit per tck_rise in Shift states, with tdi entering the MSB and the LSB presented to tdo.
REQ-018 SHALL update tdo only on tck_fall and hold it otherwise; tdo SHALL be 0 when tdo_en=0.
REQ-019 SHALL order the BSR (IN_W+OUT_W bits) as bits [IN_W-1:0] = input cells, then the output cells, with bit 0 nearest tdo.
REQ-020 SHALL make BSR Capture-DR load pin_in into the input cells and core_out into the output cells, under both EXTEST and SAMPLE.
REQ-021 SHALL copy the BSR into the BSR update latch in Update-DR under EXTEST or SAMPLE only.
REQ-022 SHALL drive pin_out from the output-cell update latch and core_in from the input-cell update latch under EXTEST; otherwise pin_out=core_out and core_in=pin_in, combinationally.
REQ-023 SHALL give BYPASS a 1-bit register that captures 0 in Capture-DR.
REQ-024 SHALL leave the BSR and its update latch unchanged in Shift-DR when BYPASS or IDCODE is selected.
REQ-025 SHALL make the mode switch to EXTEST take effect on the clk after the Update-IR tck_rise.

Reset
REQ-026 SHALL on reset force: TAP = Test-Logic-Reset, active IR = default instruction, all shift stages and update latches = 0, tdo = 0, tdo_en = 0, edge detectors cleared.
REQ-027 SHALL allow reset mid-shift to abort the operation without updating any latch; after reset, pin_out=core_out and core_in=pin_in.

Configuration
REQ-028 SHALL include the 32-bit IDCODE register when JTAG_IDCODE_EN is defined: the default instruction is IDCODE, and Capture-DR loads IDCODE_VAL.
REQ-029 SHALL, without JTAG_IDCODE_EN, omit the IDCODE register: opcode 2 decodes as BYPASS and the default instruction is BYPASS.

Verification
REQ-030 SHALL test TLR entry: from Shift-DR, 5 tck cycles with tms=1 -> TAP in Test-Logic-Reset; IR = IDCODE (macro on) or BYPASS (macro off).
REQ-031 SHALL test IDCODE read (macro on): after reset go to Shift-DR and shift 32 bits -> tdo sequence LSB-first equals 32'h1000_0001.
REQ-032 SHALL test BYPASS: load IR=3'b111, shift tdi pattern 1,0,1,1 in Shift-DR -> tdo emits 0,1,0,1 (delayed by one bit).
REQ-033 SHALL test SAMPLE: pin_in=11'h5A5, core_out=11'h2C3, Capture-DR then shift 22 bits -> tdo yields 22'h2C3<<11 | 22'h5A5 LSB-first; pin_out and core_in stay transparent.
REQ-034 SHALL test EXTEST: PRELOAD with output cells = 11'h7FF, then load EXTEST -> pin_out = 11'h7FF regardless of core_out; load BYPASS -> pin_out follows core_out.
REQ-035 SHALL test reset: assert reset mid-Shift-DR under EXTEST -> tdo_en=0 and pin_out=core_out within one clk; the update latch reads 0 on the next PRELOAD capture cycle.
